// File: rtl/modmul_param_if.sv
// Word-wide load/unload bus and start/busy/done handshake for the modular arithmetic unit.
interface modmul_param_if #(
    parameter int W = 16
);
    logic [W-1:0] datain;
    logic         load_a;
    logic         load_b;
    logic         load_p;
    logic         mode;
    logic         start;
    logic         rd_c;
    logic [W-1:0] dataout;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output datain, load_a, load_b, load_p, mode, start, rd_c,
        input  dataout, busy, done, err
    );

    modport slave (
        input  datain, load_a, load_b, load_p, mode, start, rd_c,
        output dataout, busy, done, err
    );
endinterface

// File: rtl/modmul_param.sv
// Word-serial modular unit: C = A*B mod P (MSB-first interleaved shift-add) or C = (A+B) mod P.
module modmul_param #(
    parameter int N  = 256,
    parameter int W  = 16,
    parameter int CW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    modmul_param_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CHECK, RUN, FIN} state_t;

    state_t        state;
    logic [N-1:0]  a, b, p, c, r;
    logic [CW-1:0] cnt;
    logic          mode_q;
    logic          busy_q, done_q, err_q;

    // With R < P and B < P, T < 3P, so two conditional subtractions always fully reduce.
    logic [N+1:0]  p2, t0, t1;
    logic [N-1:0]  mul_red;
    logic [N:0]    p1, add_sum;
    logic [N-1:0]  add_red;
    logic          range_bad;

    assign p2      = {2'b00, p};
    assign t0      = {1'b0, r, 1'b0} + (a[cnt] ? {2'b00, b} : {(N+2){1'b0}});
    assign t1      = (t0 >= p2) ? t0 - p2 : t0;
    assign mul_red = (t1 >= p2) ? N'(t1 - p2) : N'(t1);

    assign p1      = {1'b0, p};
    assign add_sum = {1'b0, a} + {1'b0, b};
    assign add_red = (add_sum >= p1) ? N'(add_sum - p1) : N'(add_sum);

    assign range_bad = (p == '0) || (a >= p) || (b >= p);

    assign bus.dataout = c[W-1:0];
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

    // NOTE: state and outputs update with non-blocking assignments so every branch
    // below sees the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            a      <= '0;
            b      <= '0;
            p      <= '0;
            c      <= '0;
            r      <= '0;
            cnt    <= '0;
            mode_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load_a) a <= {bus.datain, a[N-1:W]};
                    if (bus.load_b) b <= {bus.datain, b[N-1:W]};
                    if (bus.load_p) p <= {bus.datain, p[N-1:W]};
                    if (bus.start) begin
                        state  <= CHECK;
                        mode_q <= bus.mode;
                        busy_q <= 1'b1;
                        err_q  <= 1'b0;
                    end else if (bus.rd_c) begin
                        c <= {{W{1'b0}}, c[N-1:W]};
                    end
                end
                CHECK: begin
                    if (range_bad) begin
                        err_q  <= 1'b1;
                        c      <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= FIN;
                    end else begin
                        r     <= '0;
                        cnt   <= CW'(N - 1);
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (mode_q) begin
                        c      <= add_red;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= FIN;
                    end else begin
                        r   <= mul_red;
                        cnt <= cnt - CW'(1);
                        if (cnt == '0) begin
                            c      <= mul_red;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= FIN;
                        end
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_modmul_param.sv
// Self-checking bench: N=16/W=8 directed scenarios plus one N=256/W=16 multiply, with a result scoreboard.
module tb_modmul_param;
    typedef struct {
        logic [255:0] c;
        logic         err;
        int           lat;
    } exp_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    modmul_param_if #(.W(8))  s_if ();
    modmul_param_if #(.W(16)) l_if ();

    modmul_param #(.N(16),  .W(8))  u_small (.clk(clk), .rst(rst), .bus(s_if));
    modmul_param #(.N(256), .W(16)) u_large (.clk(clk), .rst(rst), .bus(l_if));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (s_if.done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [255:0] a, b, p, input logic m, input int n);
        exp_t e;
        logic [511:0] wa, wb, wp;
        wa = {256'b0, a};
        wb = {256'b0, b};
        wp = {256'b0, p};
        e.err = (p == 0) || (a >= p) || (b >= p);
        if (e.err) e.c = '0;
        else if (m) e.c = 256'((wa + wb) % wp);
        else        e.c = 256'((wa * wb) % wp);
        e.lat = e.err ? 2 : (m ? 3 : n + 2);
        return e;
    endfunction

    // ---- small (N=16, W=8) helpers; all start and end just after a falling edge ----
    logic [15:0] sa, sb_op, sp;

    task automatic s_load(input int which, input logic [15:0] v);
        for (int i = 0; i < 2; i++) begin
            s_if.datain = v[i*8 +: 8];
            s_if.load_a = (which == 0);
            s_if.load_b = (which == 1);
            s_if.load_p = (which == 2);
            @(negedge clk);
        end
        s_if.load_a = 1'b0;
        s_if.load_b = 1'b0;
        s_if.load_p = 1'b0;
        if (which == 0) sa = v;
        else if (which == 1) sb_op = v;
        else sp = v;
    endtask

    task automatic s_start(input logic m);
        sb.push_back(model({240'b0, sa}, {240'b0, sb_op}, {240'b0, sp}, m, 16));
        s_if.mode  = m;
        s_if.start = 1'b1;
        @(negedge clk);
        s_if.start = 1'b0;
    endtask

    task automatic s_wait(input string tag, input int cnt0);
        exp_t e;
        int   cnt;
        cnt = cnt0;
        while (s_if.done !== 1'b1 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, 256'(cnt), 256'(e.lat));
        check({tag, "_busy_fin"}, 256'(s_if.busy), 256'(0));
        check({tag, "_err"}, 256'(s_if.err), 256'(e.err));
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_word%0d", tag, i), 256'(s_if.dataout), 256'(e.c[i*8 +: 8]));
            s_if.rd_c = 1'b1;
            @(negedge clk);
            s_if.rd_c = 1'b0;
        end
    endtask

    initial begin
        exp_t e;
        int   d0;
        int   cnt;
        logic [255:0] lp, lv;

        rst = 1'b0;
        s_if.datain = '0; s_if.load_a = 0; s_if.load_b = 0; s_if.load_p = 0;
        s_if.mode = 0; s_if.start = 0; s_if.rd_c = 0;
        l_if.datain = '0; l_if.load_a = 0; l_if.load_b = 0; l_if.load_p = 0;
        l_if.mode = 0; l_if.start = 0; l_if.rd_c = 0;
        sa = '0; sb_op = '0; sp = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 256'(s_if.busy), 256'(0));
        check("rst_done", 256'(s_if.done), 256'(0));
        check("rst_err", 256'(s_if.err), 256'(0));
        check("rst_dataout", 256'(s_if.dataout), 256'(0));
        check("rst_large_dataout", 256'(l_if.dataout), 256'(0));
        rst = 1'b1;
        @(negedge clk);

        // Multiply, expected C = 0x5C9A.
        s_load(2, 16'hFFF1);
        s_load(0, 16'h1234);
        s_load(1, 16'h5678);
        check("mul_model", sb.size() == 0 ? model(256'h1234, 256'h5678, 256'hFFF1, 0, 16).c : '1, 256'h5C9A);
        s_start(1'b0);
        check("mul_busy", 256'(s_if.busy), 256'(1));
        s_wait("mul", 1);

        // Busy protection: load, rd_c and start mid-run must all be ignored.
        d0 = done_cnt;
        s_start(1'b0);
        repeat (4) @(negedge clk);
        s_if.datain = 8'hFF; s_if.load_a = 1; s_if.rd_c = 1; s_if.start = 1;
        @(negedge clk);
        s_if.load_a = 0; s_if.rd_c = 0; s_if.start = 0;
        check("prot_busy", 256'(s_if.busy), 256'(1));
        s_wait("prot", 6);
        repeat (3) @(negedge clk);
        check("prot_one_done", 256'(done_cnt), 256'(d0 + 1));

        // Add mode, with and without the wrap subtraction.
        s_load(0, 16'hFFF0);
        s_load(1, 16'h0005);
        s_start(1'b1);
        s_wait("add_wrap", 1);
        s_load(0, 16'h0001);
        s_load(1, 16'h0002);
        s_start(1'b1);
        s_wait("add_small", 1);

        // Range error, then cleared by the next start.
        s_load(0, 16'hFFF1);
        s_start(1'b0);
        s_wait("range", 1);
        check("range_sticky", 256'(s_if.err), 256'(1));
        s_load(0, 16'h0000);
        s_start(1'b0);
        check("range_clear", 256'(s_if.err), 256'(0));
        s_wait("range_ok", 1);

        // Reset in RUN cycle 7 aborts with no done pulse.
        s_load(0, 16'h1234);
        s_load(1, 16'h5678);
        d0 = done_cnt;
        s_if.mode = 0; s_if.start = 1;
        @(negedge clk);
        s_if.start = 0;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", 256'(s_if.busy), 256'(0));
        check("abort_dataout", 256'(s_if.dataout), 256'(0));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_done", 256'(done_cnt), 256'(d0));
        s_load(2, 16'hFFF1);
        s_load(0, 16'h1234);
        s_load(1, 16'h5678);
        s_start(1'b0);
        s_wait("rerun", 1);

        // N=256, W=16: (P-1)^2 mod P = 1 with P = 2^255-19.
        lp = (256'b1 << 255) - 256'd19;
        lv = lp - 256'd1;
        for (int i = 0; i < 16; i++) begin
            l_if.datain = lp[i*16 +: 16];
            l_if.load_p = 1;
            @(negedge clk);
        end
        l_if.load_p = 0;
        for (int i = 0; i < 16; i++) begin
            l_if.datain = lv[i*16 +: 16];
            l_if.load_a = 1;
            l_if.load_b = 1;
            @(negedge clk);
        end
        l_if.load_a = 0;
        l_if.load_b = 0;
        sb.push_back(model(lv, lv, lp, 1'b0, 256));
        check("big_model", sb[0].c, 256'd1);
        l_if.mode = 0; l_if.start = 1;
        @(negedge clk);
        l_if.start = 0;
        cnt = 1;
        while (l_if.done !== 1'b1 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        e = sb.pop_front();
        check("big_latency", 256'(cnt), 256'(e.lat));
        check("big_err", 256'(l_if.err), 256'(e.err));
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("big_word%0d", i), 256'(l_if.dataout), 256'(e.c[i*16 +: 16]));
            l_if.rd_c = 1;
            @(negedge clk);
            l_if.rd_c = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/modmul_param.md
Name: modmul_param

Overview:
- Parametrised word-serial modular arithmetic unit; computes C = A*B mod P (interleaved shift-add, MSB-first, one multiplier bit per cycle) or C = (A+B) mod P.
- Operands and modulus load over a narrow W-bit bus; the result unloads over the same word width.
- Sits beside the controller that sequences modular operations and replaces a fixed-width multiplier.
- Adds start/busy/done handshake, operand range checking and an add mode.

Parameters:
- N, 256, operand/modulus width in bits; must be a multiple of W and at least 2*W.
- W, 16, bus word width in bits.
- CW, $clog2(N), bit-index counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- datain  input  W  load data word.
- load_a  input  1  shift datain into A register (LS word first).
- load_b  input  1  shift datain into B register (LS word first).
- load_p  input  1  shift datain into P register (LS word first).
- mode  input  1  0 = multiply, 1 = add; sampled with start.
- start  input  1  begin operation; single-cycle pulse.
- rd_c  input  1  advance result output by one word.
- dataout  output  W  current result word, C[W-1:0].
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  sticky range error from the last operation.

Behaviour:
- Reset (rst=0, async): A, B, P, C, R, counter and err clear to 0; FSM goes to IDLE; busy=0, done=0, dataout=0. Reset mid-operation aborts immediately with no done pulse.
- Loads (IDLE only):
  - Each load_x cycle performs X <= {datain, X[N-1:W]}. N/W pulses fill the register.
  - Loads during busy are ignored.
  - Simultaneous load_a/load_b/load_p all take effect independently.
- rd_c (IDLE only): C <= {W'b0, C[N-1:W]}. Ignored while busy. rd_c and start in the same cycle: start wins and rd_c is dropped.
- FSM states: IDLE, CHECK, RUN, FIN.
  - IDLE: start=1 -> CHECK. Latch mode, set busy=1 and clear err. start while busy is ignored.
  - CHECK (1 cycle): if P==0, A>=P or B>=P, set err=1, C=0 -> FIN. Otherwise R=0, counter=N-1 -> RUN.
  - RUN, multiply (N cycles), per cycle:
    - T = 2R + (A[counter] ? B : 0), in N+2 bits.
    - Subtract P while T>=P, at most twice, combinationally.
    - R <= T; counter decrements.
    - When counter==0, C <= reduced value -> FIN.
  - RUN, add (1 cycle): T = A + B in N+1 bits; C <= (T>=P) ? T-P : T -> FIN.
  - FIN: done=1 for exactly this cycle, busy=0 -> IDLE.
- Latency, from the cycle start is sampled to the done cycle:
  - Multiply: N+2 cycles.
  - Add: 3 cycles.
  - Error: 2 cycles.
- busy is high from the cycle after start through the last RUN cycle, and low in FIN.
- Invariant: 0 <= R < P at every RUN edge. Arithmetic is unsigned with no overflow; internal widths are N+2.
- err holds until the next start or reset. A, B and P are preserved after an operation, so back-to-back operations may reuse operands.
- dataout is combinational from C[W-1:0].

Test Plan (N=16, W=8 unless noted):
- Reset, then multiply: load P=0xFFF1, A=0x1234, B=0x5678, start with mode=0 -> done exactly 18 cycles later, err=0; dataout=0x9A, then after rd_c dataout=0x5C (C=0x5C9A).
- Add mode: A=0xFFF0, B=0x0005, P=0xFFF1, start with mode=1 -> done 3 cycles later, C=0x0004. Repeat with A=1, B=2 -> C=0x0003.
- Range error: A=0xFFF1, P=0xFFF1, start -> done 2 cycles later, err=1, C=0. A second start with A=0 -> err clears, C=0.
- Busy protection: during a multiply, pulse load_a=0xFF, rd_c and start -> A unchanged, result still 0x5C9A, only one done pulse.
- Reset mid-operation: drop rst at RUN cycle 7 -> busy=0, C=0, no done; after release, reload and rerun -> correct 0x5C9A.
- N=256, W=16: P=2^255-19, A=P-1, B=P-1 -> C=1 after 258 cycles; 16 rd_c pulses return words 0x0001, 0x0000 x15.
